fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/fifo_wr_arb_if.sv | 29 ++
 rtl/fifo_wr_arb_rr_pick.sv | 32 +++
 rtl/fifo_wr_arb.sv | 112 +++++++++++
 tb/tb_fifo_wr_arb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: state encoding
// and default parameter values.
package fifo_arb_pkg;

   localparam int unsigned NREQ_DEF      = 4;
   localparam int unsigned DW_DEF        = 8;
   localparam int unsigned BURST_MAX_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester side and FIFO write-port side of the arbiter, bundled as one interface.
interface fifo_wr_arb_if #(
   parameter int unsigned NREQ = fifo_arb_pkg::NREQ_DEF,
   parameter int unsigned DW   = fifo_arb_pkg::DW_DEF
);
   localparam int unsigned IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_full;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_din;
   logic [IDW-1:0]     grant_id;
   logic               busy;

   // master: the arbiter, which drives the FIFO write port
   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );

   // slave: the requesters and the FIFO around the arbiter
   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester scanning upward
// from last_i+1 with wrap-around.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   localparam int unsigned IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  last_i,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;

   // Rotate so bit 0 of rot is the requester just above last_i, then take the lowest set bit.
   always_comb begin
      dbl   = {valid_i, valid_i};
      rot   = NREQ'(dbl >> (int'(last_i) + 1));
      idx_o = '0;
      any_o = 1'b0;
      for (int j = int'(NREQ) - 1; j >= 0; j--) begin
         if (rot[j]) begin
            any_o = 1'b1;
            idx_o = IDW'((int'(last_i) + 1 + j) % int'(NREQ));
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter merging NREQ valid/ready requesters into one FIFO write
// port, with bursts capped at BURST_MAX beats and one idle cycle per arbitration.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = NREQ_DEF,
   parameter int unsigned DW        = DW_DEF,
   parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
   input logic           clk,
   input logic           reset,
   fifo_wr_arb_if.master bus
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned BW  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] last_q,  last_d;
   logic [BW-1:0]  beat_q,  beat_d;

   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic [DW-1:0]   lane [NREQ];
   logic [NREQ-1:0] ready_c;
   logic            wr_en_c;
   logic [DW-1:0]   din_c;
   logic            busy_c;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid_i (bus.req_valid),
      .last_i  (last_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Split the packed data bus into per-requester lanes.
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         lane[i] = bus.req_data[i*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      ready_c = '0;
      wr_en_c = 1'b0;
      din_c   = '0;
      busy_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               beat_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            busy_c           = 1'b1;
            ready_c[grant_q] = ~bus.fifo_full;
            din_c            = lane[grant_q];
            wr_en_c          = bus.req_valid[grant_q] & ~bus.fifo_full;
            // A full FIFO with valid still high simply holds everything.
            if (!bus.req_valid[grant_q]) begin
               last_d  = grant_q;
               state_d = IDLE;
            end else if (wr_en_c) begin
               if (beat_q == BW'(BURST_MAX - 1)) begin
                  last_d  = grant_q;
                  beat_d  = '0;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset suppresses any write or handshake in the cycle it is asserted.
      if (!reset) begin
         ready_c = '0;
         wr_en_c = 1'b0;
         din_c   = '0;
         busy_c  = 1'b0;
      end
   end

   assign bus.req_ready  = ready_c;
   assign bus.fifo_wr_en = wr_en_c;
   assign bus.fifo_din   = din_c;
   assign bus.busy       = busy_c;
   assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a queue-based model.
module tb_fifo_wr_arb;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned BMAX  = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned IDW   = $clog2(NREQ);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

   fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Requester data waiting to be presented, the FIFO contents, and a write log.
   logic [DW-1:0] rq_q [NREQ][$];
   logic [DW-1:0] fq [$];
   int            wlog_id [$];
   logic [DW-1:0] wlog_dat [$];

   // Model: granted requester (-1 = none), beats so far, last winner, shown grant id.
   int m_cur   = -1;
   int m_beats = 0;
   int m_last  = NREQ - 1;
   int m_gid   = 0;

   logic [NREQ-1:0] obs_ready;
   logic            obs_wr;
   logic [DW-1:0]   obs_din;
   logic [IDW-1:0]  obs_gid;
   logic            obs_busy;

   function automatic int pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= int'(NREQ); k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, advance model and environment.
   task automatic cyc(input string tag, input logic rst_v, input logic [NREQ-1:0] v_arg,
                      input logic ffull, input logic rd);
      logic [NREQ-1:0]    v;
      logic [NREQ*DW-1:0] pd;
      logic               full;
      logic [NREQ-1:0]    e_ready;
      logic               e_wr;
      logic [DW-1:0]      e_din;
      logic [IDW-1:0]     e_gid;
      logic               e_busy;
      int                 p;
      v  = '0;
      pd = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (rq_q[i].size() > 0) begin
            v[i] = v_arg[i];
            pd[i*DW +: DW] = rq_q[i][0];
         end
      end
      full           = ffull || (fq.size() >= DEPTH);
      reset          = rst_v;
      bus.req_valid  = v;
      bus.req_data   = pd;
      bus.fifo_full  = full;
      @(negedge clk);
      e_ready = '0;
      e_wr    = 1'b0;
      e_din   = '0;
      e_busy  = 1'b0;
      e_gid   = IDW'(m_gid);
      if (rst_v && m_cur >= 0) begin
         e_busy         = 1'b1;
         e_ready[m_cur] = !full;
         e_wr           = v[m_cur] && !full;
         e_din          = pd[m_cur*DW +: DW];
      end
      obs_ready = bus.req_ready;
      obs_wr    = bus.fifo_wr_en;
      obs_din   = bus.fifo_din;
      obs_gid   = bus.grant_id;
      obs_busy  = bus.busy;
      n_cmp++;
      if (obs_ready !== e_ready || obs_wr !== e_wr || obs_din !== e_din ||
          obs_gid !== e_gid || obs_busy !== e_busy) begin
         n_bad++;
         $display("FAIL %s t=%0t: ready=%b wr=%b din=%h gid=%0d busy=%b, required ready=%b wr=%b din=%h gid=%0d busy=%b",
                  tag, $time, obs_ready, obs_wr, obs_din, obs_gid, obs_busy,
                  e_ready, e_wr, e_din, e_gid, e_busy);
      end
      if (obs_wr === 1'b1) begin
         fq.push_back(obs_din);
         wlog_id.push_back(int'(obs_gid));
         wlog_dat.push_back(obs_din);
      end
      if (e_wr) void'(rq_q[m_cur].pop_front());
      if (!rst_v) begin
         m_cur = -1; m_beats = 0; m_gid = 0; m_last = NREQ - 1;
      end else if (m_cur < 0) begin
         p = pick(v, m_last);
         if (p >= 0) begin
            m_cur = p; m_gid = p; m_beats = 0;
         end
      end else if (!v[m_cur]) begin
         m_last = m_cur; m_cur = -1;
      end else if (e_wr) begin
         m_beats++;
         if (m_beats == int'(BMAX)) begin
            m_last = m_cur; m_cur = -1;
         end
      end
      if (rd && fq.size() > 0) void'(fq.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < int'(NREQ); i++) rq_q[i].delete();
      fq.delete();
      wlog_id.delete();
      wlog_dat.delete();
      cyc("reset", 1'b0, '0, 1'b0, 1'b0);
      cyc("reset", 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      reset         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      @(posedge clk);
      #1;

      // Reset state, then a single requester streaming two beats.
      do_reset();
      cyc("idle", 1'b1, '0, 1'b0, 1'b0);
      chk("rst_outputs", {obs_ready, obs_wr, obs_din, obs_busy}, 0);
      chk("rst_gid", int'(obs_gid), 0);
      rq_q[2] = '{8'h11, 8'h22};
      cyc("r2", 1'b1, 4'b0100, 1'b0, 1'b1);
      chk("r2_arb_cycle", {obs_wr, obs_busy}, 0);
      cyc("r2", 1'b1, 4'b0100, 1'b0, 1'b1);
      chk("r2_beat1", {obs_wr, obs_din, 6'(obs_gid), obs_busy}, {1'b1, 8'h11, 6'd2, 1'b1});
      cyc("r2", 1'b1, 4'b0100, 1'b0, 1'b1);
      chk("r2_beat2", {obs_wr, obs_din}, {1'b1, 8'h22});
      cyc("r2", 1'b1, 4'b0100, 1'b0, 1'b1);
      chk("r2_done", int'(obs_wr), 0);

      // All requesters continuously valid: 4-beat bursts in order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < int'(NREQ); i++)
         for (int k = 0; k < 8; k++) rq_q[i].push_back(8'(i*16 + k));
      for (int c = 0; c < 25; c++) cyc("all", 1'b1, '1, 1'b0, 1'b1);
      chk("all_writes", wlog_id.size(), 20);
      for (int k = 0; k < wlog_id.size() && k < 20; k++)
         chk("all_order", wlog_id[k], (k / 4) % 4);

      // FIFO full for three cycles after the second beat of requester 1.
      do_reset();
      rq_q[1] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int c = 0; c < 9; c++) begin
         cyc("stall", 1'b1, 4'b0010, (c >= 3 && c <= 5), 1'b1);
         if (c >= 3 && c <= 5) chk("stall_hold", {obs_ready, obs_wr}, 0);
         if (c == 6) chk("stall_beat3", int'(obs_din), 'hA3);
         if (c == 7) chk("stall_beat4", int'(obs_din), 'hA4);
      end
      chk("stall_count", wlog_dat.size(), 4);
      if (wlog_dat.size() == 4)
         chk("stall_data", {wlog_dat[0], wlog_dat[1], wlog_dat[2], wlog_dat[3]}, 32'hA1A2A3A4);

      // Fill a 16-deep FIFO with no reads; the 17th word waits for a slot.
      do_reset();
      for (int k = 0; k < 16; k++) rq_q[0].push_back(8'(8'hFF - k));
      rq_q[0].push_back(8'h11);
      for (int c = 0; c < 26; c++) cyc("fill", 1'b1, 4'b0001, 1'b0, 1'b0);
      chk("fill_count", fq.size(), 16);
      if (fq.size() == 16) chk("fill_ends", {fq[0], fq[15]}, 16'hFFF0);
      chk("fill_held", {obs_ready, obs_wr, obs_busy}, 6'b000001);
      cyc("fill", 1'b1, 4'b0001, 1'b0, 1'b1);
      chk("fill_still_full", int'(obs_wr), 0);
      cyc("fill", 1'b1, 4'b0001, 1'b0, 1'b0);
      chk("fill_resume", {obs_wr, obs_din}, {1'b1, 8'h11});

      // Reset during the second beat of requester 3.
      do_reset();
      rq_q[3] = '{8'h31, 8'h32, 8'h33, 8'h34};
      rq_q[0] = '{8'h01, 8'h02};
      cyc("rst3", 1'b1, 4'b1000, 1'b0, 1'b1);
      cyc("rst3", 1'b1, 4'b1000, 1'b0, 1'b1);
      chk("rst3_beat1", {obs_wr, obs_din}, {1'b1, 8'h31});
      cyc("rst3", 1'b0, 4'b1000, 1'b0, 1'b1);
      chk("rst3_abort", {obs_ready, obs_wr, obs_din, obs_busy}, 0);
      cyc("rst3", 1'b1, 4'b1001, 1'b0, 1'b1);
      chk("rst3_idle", {obs_wr, obs_busy, 6'(obs_gid)}, 0);
      cyc("rst3", 1'b1, 4'b1001, 1'b0, 1'b1);
      chk("rst3_req0_first", {obs_wr, 6'(obs_gid), obs_din}, {1'b1, 6'd0, 8'h01});

      // Requester 1 drops valid after one beat; next grant goes above 1.
      do_reset();
      rq_q[1] = '{8'h51, 8'h52, 8'h53, 8'h54};
      rq_q[0] = '{8'h61};
      rq_q[3] = '{8'h71, 8'h72};
      cyc("drop", 1'b1, 4'b0010, 1'b0, 1'b1);
      cyc("drop", 1'b1, 4'b0010, 1'b0, 1'b1);
      chk("drop_beat1", {obs_wr, obs_din}, {1'b1, 8'h51});
      cyc("drop", 1'b1, 4'b1001, 1'b0, 1'b1);
      chk("drop_end", {obs_wr, obs_busy}, 2'b01);
      cyc("drop", 1'b1, 4'b1001, 1'b0, 1'b1);
      chk("drop_bubble", int'(obs_busy), 0);
      cyc("drop", 1'b1, 4'b1001, 1'b0, 1'b1);
      chk("drop_next", {obs_wr, 6'(obs_gid), obs_din}, {1'b1, 6'd3, 8'h71});

      // Random traffic: valid toggling, FIFO back-pressure, occasional reset.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [NREQ-1:0] v;
         for (int i = 0; i < int'(NREQ); i++) begin
            if (rq_q[i].size() < 2) rq_q[i].push_back(8'($urandom));
            v[i] = ($urandom_range(0, 3) != 0);
         end
         cyc("rand", ($urandom_range(0, 299) != 0), v,
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
